// File: rtl/snn_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron ring.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        COMMIT
    } state_t;

    function automatic logic [31:0] sat_u(
        input logic signed [31:0] s,
        input int                 width
    );
        logic signed [31:0] hi;
        hi = (32'sd1 <<< width) - 32'sd1;
        if (s < 32'sd0)
            return '0;
        else if (s > hi)
            return hi;
        else
            return s;
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// One LIF step for a single slot: leak, bias, coupling, stimulus,
// saturate to the unsigned membrane range, then fire-and-reset.
module lif_update_unit
    import snn_pkg::*;
#(
    parameter int V_WIDTH    = 8,
    parameter int W_WIDTH    = 5,
    parameter int LEAK_SHIFT = 3,
    parameter int BIAS       = 1,
    parameter int STIM       = 8
) (
    input  logic [V_WIDTH-1:0]        v,
    input  logic [V_WIDTH-1:0]        thr,
    input  logic signed [W_WIDTH-1:0] weight,
    input  logic                      spk_in,
    input  logic                      stim,
    output logic [V_WIDTH-1:0]        v_nxt,
    output logic                      fire
);

    localparam int SW = V_WIDTH + W_WIDTH + 2;
    localparam logic signed [SW-1:0] BIAS_S = SW'(BIAS);
    localparam logic signed [SW-1:0] STIM_S = SW'(STIM);

    logic signed [SW-1:0] v_ext;
    logic signed [SW-1:0] leak_ext;
    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] s;
    logic [31:0]          sc;

    assign v_ext    = $signed({{(SW-V_WIDTH){1'b0}}, v});
    assign leak_ext = $signed({{(SW-V_WIDTH){1'b0}}, v >> LEAK_SHIFT});
    assign w_ext    = $signed({{(SW-W_WIDTH){weight[W_WIDTH-1]}}, weight});

    always_comb begin
        s = v_ext - leak_ext + BIAS_S;
        if (spk_in)
            s = s + w_ext;
        if (stim)
            s = s + STIM_S;
    end

    assign sc    = sat_u({{(32-SW){s[SW-1]}}, s}, V_WIDTH);
    assign fire  = (sc >= {{(32-V_WIDTH){1'b0}}, thr});
    assign v_nxt = fire ? '0 : sc[V_WIDTH-1:0];

endmodule

// File: rtl/neuron_update_sequencer.sv
// Sweeps one shared LIF datapath over an N-slot membrane register file
// once per timestep tick; slot i is coupled to the spike of slot i-1.
module neuron_update_sequencer
    import snn_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int V_WIDTH    = 8,
    parameter int W_WIDTH    = 5,
    parameter int TICK_DIV   = 1000,
    parameter int LEAK_SHIFT = 3,
    parameter int BIAS       = 1,
    parameter int STIM       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [V_WIDTH-1:0]           threshold,
    input  logic signed [W_WIDTH-1:0]    weight,
    input  logic [N_NEURONS-1:0]         ext_stim,
    input  logic [$clog2(N_NEURONS)-1:0] mon_sel,
    output logic [N_NEURONS-1:0]         spike,
    output logic [V_WIDTH-1:0]           vmem_mon,
    output logic                         busy,
    output logic                         step_done,
    output logic                         overrun
);

    localparam int IW = $clog2(N_NEURONS);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_NEURONS - 1);

    state_t                     state;
    state_t                     state_nxt;
    logic [CW-1:0]              cnt;
    logic                       tick;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              idx_prev;
    logic [V_WIDTH-1:0]         vmem [N_NEURONS];
    logic [N_NEURONS-1:0]       spike_nxt;
    logic [V_WIDTH-1:0]         thr_q;
    logic signed [W_WIDTH-1:0]  w_q;
    logic [V_WIDTH-1:0]         v_new;
    logic                       fire;

    assign tick     = ena && (cnt == CNT_MAX);
    assign busy     = (state != IDLE);
    assign idx_prev = (idx == '0) ? IDX_MAX : idx - 1'b1;

    lif_update_unit #(
        .V_WIDTH    (V_WIDTH),
        .W_WIDTH    (W_WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT),
        .BIAS       (BIAS),
        .STIM       (STIM)
    ) u_lif (
        .v      (vmem[idx]),
        .thr    (thr_q),
        .weight (w_q),
        .spk_in (spike[idx_prev]),
        .stim   (ext_stim[idx]),
        .v_nxt  (v_new),
        .fire   (fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (ena)
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (tick) state_nxt = UPDATE;
            UPDATE:  if (idx == IDX_MAX) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The committed spike vector stays frozen for the whole sweep so
    // every slot couples to the previous timestep, not a partial one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            thr_q     <= '0;
            w_q       <= '0;
            spike     <= '0;
            spike_nxt <= '0;
            step_done <= 1'b0;
            overrun   <= 1'b0;
            vmem_mon  <= '0;
            for (int i = 0; i < N_NEURONS; i++)
                vmem[i] <= '0;
        end else begin
            state     <= state_nxt;
            step_done <= (state == COMMIT);
            vmem_mon  <= vmem[mon_sel];
            if (tick && busy)
                overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        thr_q <= threshold;
                        w_q   <= weight;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    vmem[idx]      <= v_new;
                    spike_nxt[idx] <= fire;
                    idx            <= idx + 1'b1;
                end
                COMMIT:  spike <= spike_nxt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// Scoreboard bench: four sequencer configurations exercised in turn,
// expected spike/monitor values queued at drive time and popped on step_done.
module tb_neuron_update_sequencer;

    typedef struct packed {
        logic [3:0] spk;
        logic [7:0] vm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ena_v;
    logic [7:0] thr;
    logic [4:0] w;
    logic [3:0] es;
    logic [1:0] sel;
    logic [1:0] act;

    logic [3:0] spk_a [4];
    logic [7:0] vm_a  [4];
    logic [3:0] bsy_a;
    logic [3:0] dn_a;
    logic [3:0] ov_a;

    logic [3:0] spk_m;
    logic [7:0] vm_m;
    logic       bsy_m;
    logic       dn_m;
    logic       ov_m;

    exp_t sbq [$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mv [4];
    logic [3:0] ms;
    int   bias_m;
    int   stim_m;
    int   n;
    int   off;

    always #5 clk = ~clk;

    assign spk_m = spk_a[act];
    assign vm_m  = vm_a[act];
    assign bsy_m = bsy_a[act];
    assign dn_m  = dn_a[act];
    assign ov_m  = ov_a[act];

    neuron_update_sequencer #(
        .N_NEURONS(4), .V_WIDTH(8), .W_WIDTH(5), .TICK_DIV(16),
        .LEAK_SHIFT(3), .BIAS(1), .STIM(8)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena_v[0]), .threshold(thr),
        .weight(w), .ext_stim(es), .mon_sel(sel), .spike(spk_a[0]),
        .vmem_mon(vm_a[0]), .busy(bsy_a[0]), .step_done(dn_a[0]),
        .overrun(ov_a[0])
    );

    neuron_update_sequencer #(
        .N_NEURONS(4), .V_WIDTH(8), .W_WIDTH(5), .TICK_DIV(16),
        .LEAK_SHIFT(3), .BIAS(0), .STIM(8)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena_v[1]), .threshold(thr),
        .weight(w), .ext_stim(es), .mon_sel(sel), .spike(spk_a[1]),
        .vmem_mon(vm_a[1]), .busy(bsy_a[1]), .step_done(dn_a[1]),
        .overrun(ov_a[1])
    );

    neuron_update_sequencer #(
        .N_NEURONS(4), .V_WIDTH(8), .W_WIDTH(5), .TICK_DIV(16),
        .LEAK_SHIFT(3), .BIAS(0), .STIM(255)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena_v[2]), .threshold(thr),
        .weight(w), .ext_stim(es), .mon_sel(sel), .spike(spk_a[2]),
        .vmem_mon(vm_a[2]), .busy(bsy_a[2]), .step_done(dn_a[2]),
        .overrun(ov_a[2])
    );

    neuron_update_sequencer #(
        .N_NEURONS(4), .V_WIDTH(8), .W_WIDTH(5), .TICK_DIV(3),
        .LEAK_SHIFT(3), .BIAS(1), .STIM(8)
    ) u3 (
        .clk(clk), .rst_n(rst_n), .ena(ena_v[3]), .threshold(thr),
        .weight(w), .ext_stim(es), .mon_sel(sel), .spike(spk_a[3]),
        .vmem_mon(vm_a[3]), .busy(bsy_a[3]), .step_done(dn_a[3]),
        .overrun(ov_a[3])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dn_m) begin
            chk("sb_pending", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("spike", 32'(spk_m), 32'(mon_e.spk));
                chk("vmem_mon", 32'(vm_m), 32'(mon_e.vm));
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mv[i] = 0;
        ms = 4'b0;
    endtask

    task automatic push_exp(input logic [3:0] s, input logic [7:0] v);
        sbq.push_back(exp_t'{s, v});
    endtask

    task automatic model_step();
        logic [3:0] ns;
        int s;
        ns = 4'b0;
        for (int i = 0; i < 4; i++) begin
            s = mv[i] - (mv[i] / 8) + bias_m;
            if (ms[(i + 3) % 4]) s = s + int'($signed(w));
            if (es[i]) s = s + stim_m;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            if (s >= int'(thr)) begin
                ns[i] = 1'b1;
                mv[i] = 0;
            end else begin
                mv[i] = s;
            end
        end
        ms = ns;
        push_exp(ms, 8'(mv[sel]));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!dn_m && cyc < 300);
        chk("step_done_seen", 32'(dn_m), 32'd1);
    endtask

    task automatic wait_busy(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bsy_m && cyc < 300);
        chk("busy_seen", 32'(bsy_m), 32'd1);
    endtask

    task automatic step(input logic [7:0] t, input logic [4:0] wv,
                        input logic [3:0] e, input logic [1:0] s);
        int c;
        thr = t;
        w   = wv;
        es  = e;
        sel = s;
        model_step();
        wait_done(c);
    endtask

    task automatic do_reset();
        #2;
        ena_v = 4'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sbq.delete();
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_spike"}, 32'(spk_m), 32'd0);
        chk({tag, "_vmem"}, 32'(vm_m), 32'd0);
        chk({tag, "_busy"}, 32'(bsy_m), 32'd0);
        chk({tag, "_done"}, 32'(dn_m), 32'd0);
        chk({tag, "_ovr"}, 32'(ov_m), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ena_v = 4'b0; thr = '0; w = '0; es = '0;
        sel = '0; act = 2'd0; bias_m = 1; stim_m = 8;
        model_clear();
        repeat (3) @(negedge clk);
        chk_zero_outs("reset");

        // Pure bias integration to threshold 4
        thr = 8'd4; w = 5'd0; es = 4'b0; sel = 2'd0;
        rst_n = 1'b1; ena_v[0] = 1'b1;
        push_exp(4'h0, 8'd1);
        push_exp(4'h0, 8'd2);
        push_exp(4'h0, 8'd3);
        push_exp(4'hF, 8'd0);
        push_exp(4'h0, 8'd1);
        repeat (5) wait_done(n);
        for (int i = 0; i < 4; i++) mv[i] = 1;
        ms = 4'b0;

        // ena drops mid-sweep: sweep still completes
        model_step();
        wait_busy(n);
        ena_v[0] = 1'b0;
        wait_done(n);
        off = 0;
        repeat (40) begin
            @(negedge clk);
            if (dn_m) off++;
        end
        chk("quiet_while_off", 32'(off), 32'd0);
        model_step();
        ena_v[0] = 1'b1;
        wait_done(n);
        chk("resume_phase", 32'(n), 32'd21);
        model_step();
        wait_done(n);

        // Reset in the middle of an UPDATE sweep
        model_step();
        wait_busy(n);
        @(negedge clk);
        @(negedge clk);
        chk("ovr_u0", 32'(ov_m), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_zero_outs("mid_rst");
        sbq.delete();
        model_clear();
        model_step();
        @(negedge clk);
        rst_n = 1'b1;
        wait_busy(n);
        chk("first_sweep", 32'(n), 32'd16);
        wait_done(n);
        for (int k = 0; k < 8; k++)
            step((k == 3) ? 8'd0 : 8'($urandom_range(2, 40)),
                 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)));

        // Ring propagation, then low clamp with strong inhibition
        do_reset();
        act = 2'd1; bias_m = 0; stim_m = 8;
        thr = 8'd8; w = 5'd8; es = 4'b0001; sel = 2'd0;
        push_exp(4'b0001, 8'd0);
        ena_v[1] = 1'b1;
        wait_done(n);
        es = 4'b0;
        push_exp(4'b0010, 8'd0);
        wait_done(n);
        push_exp(4'b0100, 8'd0);
        wait_done(n);
        push_exp(4'b1000, 8'd0);
        wait_done(n);
        push_exp(4'b0001, 8'd0);
        wait_done(n);
        ms = 4'b0001;
        step(8'd9, 5'h10, 4'hF, 2'd1);
        step(8'd9, 5'h10, 4'hF, 2'd1);
        step(8'd9, 5'h10, 4'hF, 2'd2);
        step(8'd9, 5'h10, 4'hF, 2'd3);

        // High clamp with a large stimulus
        do_reset();
        act = 2'd2; bias_m = 0; stim_m = 255;
        ena_v[2] = 1'b1;
        step(8'd255, 5'd0, 4'hF, 2'd0);
        step(8'd255, 5'd15, 4'hF, 2'd1);
        step(8'd200, 5'h10, 4'h0, 2'd2);
        step(8'd255, 5'd0, 4'h5, 2'd0);
        step(8'd0, 5'd0, 4'h0, 2'd3);

        // Tick period shorter than a sweep
        do_reset();
        act = 2'd3; bias_m = 1; stim_m = 8;
        chk("ovr_after_rst", 32'(ov_m), 32'd0);
        ena_v[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(8'd6, 5'd3, 4'($urandom_range(0, 15)), 2'(k));
            chk("ovr_sticky", 32'(ov_m), 32'd1);
        end
        do_reset();
        #1;
        chk("ovr_cleared", 32'(ov_m), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
